// File: rtl/multi_clk_divider.sv
// N-channel programmable clock divider producing 50% square outputs plus rise/fall
// enable ticks, with run-time threshold reload, per-channel gating and phase-align restart.
`timescale 1ns/1ps
module multi_clk_divider #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      CNT_W       = 24,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(100)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH*CNT_W-1:0] div_threshold,
    input  logic                    load,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_tick,
    output logic [NUM_CH-1:0]       fall_tick,
    output logic [NUM_CH-1:0]       update_pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } ch_state_e;

    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [CNT_W-1:0] thr_q   [NUM_CH];
    logic [CNT_W-1:0] thr_d   [NUM_CH];
    logic [CNT_W-1:0] pend_q  [NUM_CH];
    logic [CNT_W-1:0] pend_d  [NUM_CH];

    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] upd_q, upd_d;

    logic [CNT_W-1:0] slice;
    logic             run;
    logic             wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                thr_q[i]   <= DEFAULT_DIV;
                pend_q[i]  <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            upd_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                thr_q[i]   <= thr_d[i];
                pend_q[i]  <= pend_d[i];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            upd_q  <= upd_d;
        end
    end

    always_comb begin
        slice = '0;
        run   = 1'b0;
        wrap  = 1'b0;
        out_d = out_q;
        upd_d = upd_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            slice      = div_threshold[i*CNT_W +: CNT_W];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            thr_d[i]   = thr_q[i];
            pend_d[i]  = pend_q[i];
            // A stopping channel keeps counting so its high phase finishes at full length.
            run  = ch_enable[i] || (state_q[i] == ST_STOP) || (state_q[i] == ST_RUN && out_q[i]);
            wrap = run && (cnt_q[i] == thr_q[i]);

            if (load) begin
                pend_d[i] = slice;
                upd_d[i]  = 1'b1;
            end

            if (sync_restart) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
                upd_d[i] = 1'b0;
                if (load)          thr_d[i] = slice;
                else if (upd_q[i]) thr_d[i] = pend_q[i];
                state_d[i] = ch_enable[i] ? ST_RUN : ST_IDLE;
            end else begin
                if (wrap) begin
                    cnt_d[i] = '0;
                    out_d[i] = ~out_q[i];
                    if (load) begin
                        thr_d[i] = slice;
                        upd_d[i] = 1'b0;
                    end else if (upd_q[i]) begin
                        thr_d[i] = pend_q[i];
                        upd_d[i] = 1'b0;
                    end
                end else if (run) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    cnt_d[i] = '0;
                    if (!load && upd_q[i]) begin
                        thr_d[i] = pend_q[i];
                        upd_d[i] = 1'b0;
                    end
                end

                unique case (state_q[i])
                    ST_IDLE: if (ch_enable[i]) state_d[i] = ST_RUN;
                    // Disabling on the falling wrap itself leaves nothing to finish.
                    ST_RUN:  if (!ch_enable[i]) state_d[i] = (out_q[i] && !wrap) ? ST_STOP : ST_IDLE;
                    ST_STOP: begin
                        if (ch_enable[i])  state_d[i] = ST_RUN;
                        else if (wrap)     state_d[i] = ST_IDLE;
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_comb begin
        clk_out        = out_q;
        rise_tick      = rise_q;
        fall_tick      = fall_q;
        update_pending = upd_q;
    end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- Parametrised N-channel programmable clock-enable/divider. Replaces the fixed-ratio toggle dividers used for the FSM, I2C, sampling and PMOD clocks.
- All channels run from one system clock. Each produces a 50% square output plus single-cycle rise/fall enable ticks.
- Thresholds can be changed at run time and are applied glitch-free at period boundaries.
- Supports per-channel gating and a global phase-align restart, so downstream logic can use clock enables instead of derived clocks.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 24, width of each channel's counter and threshold
- DEFAULT_DIV, 24'd100, active threshold loaded into every channel at reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_enable  in  NUM_CH  per-channel run enable
- div_threshold  in  NUM_CH*CNT_W  new thresholds; channel i in bits [i*CNT_W +: CNT_W]
- load  in  1  strobe; captures div_threshold into all channels' pending registers
- sync_restart  in  1  strobe; phase-aligns all channels
- clk_out  out  NUM_CH  divided square outputs (registered)
- rise_tick  out  NUM_CH  1-cycle pulse, registered, high in the cycle clk_out[i] first reads 1
- fall_tick  out  NUM_CH  1-cycle pulse, high in the cycle clk_out[i] first reads 0
- update_pending  out  NUM_CH  pending threshold not yet applied

Behaviour:
- Reset (async assert, sync release):
  - cnt = 0, active_thr = DEFAULT_DIV, pending_thr = 0.
  - clk_out, rise_tick, fall_tick and update_pending all 0.
- Per channel, running state (ch_enable=1 and not stopping):
  - If cnt == active_thr: toggle clk_out, cnt <= 0 (a wrap). Otherwise cnt <= cnt + 1.
  - Half period = active_thr+1 cycles; full period = 2*(active_thr+1).
  - active_thr=0 toggles every cycle (period 2).
  - cnt never exceeds active_thr. Counter arithmetic is CNT_W bits with no overflow path.
- Ticks:
  - rise_tick[i]=1 in exactly the cycles where clk_out[i] went 0->1 on the preceding edge.
  - fall_tick[i] is the same for 1->0.
  - Ticks never coincide on one channel.
- Threshold update:
  - load=1: pending_thr[i] <= slice i and update_pending[i] <= 1, for all channels.
  - Pending is applied (active_thr <= pending_thr, update_pending <= 0) at the channel's next wrap of either polarity.
  - The wrap cycle itself still uses the old threshold. The new half period starts from cnt=0.
  - If load and a wrap coincide, the just-loaded value is applied at that wrap (bypass); update_pending stays 0.
  - A second load before application overwrites pending (latest wins).
  - A disabled channel applies a load on the next cycle.
- Channel states: RUN, STOPPING, IDLE.
  - RUN -> IDLE: ch_enable falls while clk_out=0. cnt <= 0 immediately.
  - RUN -> STOPPING: ch_enable falls while clk_out=1. The high phase completes normally (no runt pulse). At the falling wrap: fall_tick, cnt <= 0, IDLE.
  - STOPPING -> RUN: ch_enable reasserted during STOPPING. The channel continues without interruption.
  - IDLE: clk_out=0, cnt held 0, no ticks.
  - IDLE -> RUN: ch_enable=1. First rise occurs active_thr+1 cycles after the first enabled edge.
- sync_restart (highest priority, all channels):
  - cnt <= 0, clk_out <= 0.
  - Pending thresholds applied immediately.
  - fall_tick asserted next cycle only for channels whose clk_out was 1.
  - Enabled channels resume in RUN. STOPPING channels go IDLE.
  - Afterwards, channels with equal thresholds are phase-identical.
- sync_restart and load in the same cycle: the new div_threshold values become active immediately.
- Reset mid-operation: all state returns to reset values asynchronously. No tick is emitted on release.

Test Plan:
- Reset release, ch_enable=4'b0001, no load -> clk_out[0] first rises 101 cycles after enable, period 202; rise_tick/fall_tick one cycle each per period; other channels stay 0.
- load with ch0 thr=4 mid high phase (thr 100) -> high phase completes at 101 cycles; update_pending[0]=1 until that wrap; subsequent half periods exactly 5 cycles.
- thr=0 on ch1 -> clk_out[1] toggles every cycle; rise_tick/fall_tick alternate every cycle.
- Deassert ch_enable[2] 3 cycles into its high phase (thr=9) -> high lasts the full 10 cycles, one fall_tick, then held low with no ticks; reassert -> first rise after 10 cycles.
- Channels with thr 3 and 7 running, pulse sync_restart with load (thr 5,5) -> both outputs low next cycle, then rise together 6 cycles later and remain phase-identical.
- Assert rst_n=0 mid-count -> outputs 0 immediately (asynchronously), active_thr back to 100, update_pending cleared.
